// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with line refill over a req/ack memory port.
// Hits return the word in the same cycle; misses stall the fetch stage until the line is refilled.
module instruction_cache #(
  parameter int INDEX_BITS      = 4,
  parameter int LINE_WORDS_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int TAG_BITS = 32 - 2 - LINE_WORDS_LOG2 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << LINE_WORDS_LOG2;
  localparam int OFF      = 2 + LINE_WORDS_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_FILL} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES][WORDS];

  logic [TAG_BITS-1:0]        rf_tag_q;
  logic [INDEX_BITS-1:0]      rf_idx_q;
  logic [LINE_WORDS_LOG2-1:0] cnt_q;
  logic                       mem_req_q;
  logic [31:0]                mem_addr_q;
  logic                       flush_pend_q;

  // Address decomposition of the fetch pc
  logic [TAG_BITS-1:0]        pc_tag;
  logic [INDEX_BITS-1:0]      pc_idx;
  logic [LINE_WORDS_LOG2-1:0] pc_word;
  logic                       unused_pc_bits;

  assign pc_tag         = pc[31:OFF+INDEX_BITS];
  assign pc_idx         = pc[OFF+INDEX_BITS-1:OFF];
  assign pc_word        = pc[OFF-1:2];
  assign unused_pc_bits = ^pc[1:0];

  logic                       hit;
  logic                       miss_start;
  logic                       ack_take;
  logic                       last_word;
  logic [LINE_WORDS_LOG2-1:0] cnt_inc;

  assign hit        = (state_q == S_IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  // A flush in the same cycle as a miss takes priority; the retry misses next cycle.
  assign miss_start = (state_q == S_IDLE) && fetch_req && !hit && !flush;
  // Acks only count while a request is actually outstanding in REFILL.
  assign ack_take   = (state_q == S_REFILL) && mem_req_q && mem_ack;
  assign last_word  = (cnt_q == {LINE_WORDS_LOG2{1'b1}});
  assign cnt_inc    = cnt_q + LINE_WORDS_LOG2'(1);

  assign instr_valid = fetch_req && hit && !flush;
  assign instr       = instr_valid ? data_q[pc_idx][pc_word] : 32'h0;
  assign stall       = fetch_req && !instr_valid;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> REFILL on miss, REFILL -> FILL on last ack, FILL is one bubble
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (miss_start) state_d = S_REFILL;
      S_REFILL: if (ack_take && last_word) state_d = S_FILL;
      S_FILL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Refill request sequencing: latch miss line, step the word address on each ack, never crossing the line
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_tag_q     <= '0;
      rf_idx_q     <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (miss_start) begin
        rf_tag_q   <= pc_tag;
        rf_idx_q   <= pc_idx;
        cnt_q      <= '0;
        mem_req_q  <= 1'b1;
        mem_addr_q <= {pc_tag, pc_idx, {LINE_WORDS_LOG2{1'b0}}, 2'b00};
      end else if (ack_take) begin
        if (last_word) begin
          mem_req_q <= 1'b0;
        end else begin
          cnt_q      <= cnt_inc;
          mem_addr_q <= {rf_tag_q, rf_idx_q, cnt_inc, 2'b00};
        end
      end
      if (state_q == S_REFILL && flush) flush_pend_q <= 1'b1;
      else if (state_q == S_FILL)       flush_pend_q <= 1'b0;
    end
  end

  // Valid bits: flush clears all; a completed refill validates its line unless a flush hit it mid-refill
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (ack_take && last_word) begin
      valid_q[rf_idx_q] <= !flush_pend_q;
    end
  end

  // Tag and data arrays: written only by accepted refill beats
  always_ff @(posedge clk) begin
    if (!rst && ack_take) begin
      data_q[rf_idx_q][cnt_q] <= mem_rdata;
      if (last_word) tag_q[rf_idx_q] <= rf_tag_q;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: cold miss, zero-latency refill, conflict, flushes, reset mid-refill, top-of-memory line.
module tb_instruction_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  // Memory contents: each word is its own address XOR a fixed pattern.
  assign mem_rdata = mem_addr ^ 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  instruction_cache dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present pc and check a same-cycle hit returning exp.
  task automatic chk_hit(input string tag, input logic [31:0] p, input logic [31:0] exp);
    pc = p; fetch_req = 1'b1; #1;
    chk({tag, "_valid"}, instr_valid, 1);
    chk({tag, "_instr"}, instr, exp);
    chk({tag, "_stall"}, stall, 0);
  endtask

  // Entered on the miss cycle with pc already presented; leaves on the first IDLE cycle after FILL.
  task automatic do_refill(input string tag, input logic [31:0] p, input int lat, input int flush_w);
    logic [31:0] base;
    base = p & 32'hFFFF_FFF0;
    chk({tag, "_miss_stall"}, stall, 1);
    chk({tag, "_miss_noreq"}, mem_req, 0);
    tick();
    for (int w = 0; w < 4; w++) begin
      for (int l = 0; l < lat; l++) begin
        chk({tag, "_wait_req"}, mem_req, 1);
        chk({tag, "_wait_addr"}, mem_addr, base + 32'(4 * w));
        chk({tag, "_wait_stall"}, stall, 1);
        flush = (w == flush_w && l == 0);
        mem_ack = 1'b0;
        tick();
        flush = 1'b0;
      end
      chk({tag, "_ack_req"}, mem_req, 1);
      chk({tag, "_ack_addr"}, mem_addr, base + 32'(4 * w));
      chk({tag, "_ack_stall"}, stall, 1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    #1;
    chk({tag, "_fill_req"}, mem_req, 0);
    chk({tag, "_fill_valid"}, instr_valid, 0);
    chk({tag, "_fill_stall"}, stall, 1);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; fetch_req = 1'b1; pc = 32'h0040_0000; flush = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    // Reset state: outputs zero, stall follows fetch_req
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_stall", stall, 1);
    fetch_req = 1'b0; #1;
    chk("rst_stall_idle", stall, 0);
    rst = 1'b0;
    tick();

    // 1. Cold miss with 2-cycle ack latency, then a hit on the next word
    pc = 32'h0040_0000; fetch_req = 1'b1; #1;
    do_refill("cold", 32'h0040_0000, 2, -1);
    chk_hit("cold_hit0", 32'h0040_0000, 32'hDEED_BEEF);
    chk_hit("cold_hit1", 32'h0040_0004, 32'hDEED_BEEB);

    // 2. Zero-latency memory: six stall cycles, then hit
    pc = 32'h0080_0010; fetch_req = 1'b1; mem_ack = 1'b1; #1;
    n = 0;
    for (int c = 0; c < 20 && !instr_valid; c++) begin
      if (stall) n++;
      tick();
    end
    mem_ack = 1'b0; #1;
    chk("zl_stall_cycles", 32'(n), 32'd6);
    chk("zl_valid", instr_valid, 1);
    chk("zl_instr", instr, 32'hDE2D_BEFF);
    chk_hit("zl_other_line", 32'h0040_000C, 32'hDEED_BEE3);

    // 3. Conflict on index 0 evicts the first line
    pc = 32'h0040_0100; #1;
    do_refill("conf_a", 32'h0040_0100, 1, -1);
    chk_hit("conf_hit", 32'h0040_0100, 32'hDEED_BFEF);
    pc = 32'h0040_0000; #1;
    chk("conf_evicted", instr_valid, 0);
    do_refill("conf_b", 32'h0040_0000, 0, -1);
    chk_hit("conf_back", 32'h0040_0000, 32'hDEED_BEEF);

    // 4. Flush in IDLE: flush cycle gives no hit and starts no refill
    flush = 1'b1; #1;
    chk("fl_idle_valid", instr_valid, 0);
    tick();
    flush = 1'b0; #1;
    chk("fl_idle_noreq", mem_req, 0);
    do_refill("fl_idle", 32'h0040_0000, 0, -1);
    chk_hit("fl_idle_hit", 32'h0040_0008, 32'hDEED_BEE7);

    // 5. Flush during the second refill word: line left invalid, retry refills again
    pc = 32'h0040_0100; #1;
    do_refill("fl_ref", 32'h0040_0100, 1, 1);
    #1;
    chk("fl_ref_retry_valid", instr_valid, 0);
    do_refill("fl_ref_again", 32'h0040_0100, 0, -1);
    chk_hit("fl_ref_hit", 32'h0040_0104, 32'hDEED_BFEB);

    // 6. Reset during REFILL with a late ack one cycle after reset
    pc = 32'h00C0_0020; #1;
    chk("rr_miss_stall", stall, 1);
    tick();
    chk("rr_req", mem_req, 1);
    chk("rr_addr", mem_addr, 32'h00C0_0020);
    rst = 1'b1;
    tick();
    rst = 1'b0; fetch_req = 1'b0; mem_ack = 1'b1; #1;
    chk("rr_req_cleared", mem_req, 0);
    chk("rr_addr_cleared", mem_addr, 32'h0);
    tick();
    mem_ack = 1'b0; #1;
    chk("rr_late_ack_noreq", mem_req, 0);
    pc = 32'h0040_0100; fetch_req = 1'b1; #1;
    chk("rr_line0_invalid", instr_valid, 0);
    do_refill("rr_line0", 32'h0040_0100, 0, -1);
    pc = 32'h00C0_0024; #1;
    do_refill("rr_fresh", 32'h00C0_0024, 1, -1);
    chk_hit("rr_fresh_hit", 32'h00C0_0024, 32'hDE6D_BECB);

    // Top-of-memory line: addresses stay inside the line
    pc = 32'hFFFF_FFFC; #1;
    do_refill("top", 32'hFFFF_FFFC, 0, -1);
    chk_hit("top_hit", 32'hFFFF_FFFC, 32'h2152_4113);
    chk_hit("top_hit0", 32'hFFFF_FFF0, 32'h2152_411F);

    fetch_req = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
